// File: rtl/wait_duration_if.sv
// Command/status bundle between the sequencer and the wait_duration timer.
interface wait_duration_if #(
   parameter int unsigned DUR_WIDTH = 32
);
   logic                 i_sel_wait_duration;
   logic                 i_args_valid;
   logic [DUR_WIDTH-1:0] i_duration;
   logic [1:0]           i_unit;
   logic                 i_abort;
   logic                 o_busy;
   logic                 o_wait_duration_done;
   logic                 o_error;

   modport master (
      output i_sel_wait_duration, i_args_valid, i_duration, i_unit, i_abort,
      input  o_busy, o_wait_duration_done, o_error
   );

   modport slave (
      input  i_sel_wait_duration, i_args_valid, i_duration, i_unit, i_abort,
      output o_busy, o_wait_duration_done, o_error
   );
endinterface

// File: rtl/wait_duration.sv
// Delay timer: converts duration+unit to ps, counts clock periods without a
// divider, and returns a one-cycle done pulse.
module wait_duration #(
   parameter int unsigned CLK_PERIOD = 20000,
   parameter int unsigned DUR_WIDTH  = 32
) (
   input  logic           clk,
   input  logic           rst,
   wait_duration_if.slave bus
);
   localparam int unsigned TW = DUR_WIDTH + 30;
   localparam int unsigned EW = DUR_WIDTH + 31;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

   state_t               r_state, w_next;
   logic [DUR_WIDTH-1:0] r_dur;
   logic [1:0]           r_unit;
   logic [TW-1:0]        r_target, w_target;
   logic [EW-1:0]        r_elapsed, w_elapsed_nxt;
   logic [29:0]          w_scale;
   logic                 w_start, w_reached;
   logic                 r_busy, r_done, r_error;

   assign w_start = bus.i_sel_wait_duration & bus.i_args_valid;

   always_comb begin
      w_scale = 30'd1;
      case (r_unit)
         2'd0:    w_scale = 30'd1;
         2'd1:    w_scale = 30'd1_000;
         2'd2:    w_scale = 30'd1_000_000;
         default: w_scale = 30'd1_000_000_000;
      endcase
   end

   assign w_target      = TW'(r_dur) * TW'(w_scale);
   assign w_elapsed_nxt = r_elapsed + EW'(CLK_PERIOD);
   // Exit on the cycle whose period would cover the target: yields ceil(target/period) cycles.
   assign w_reached     = (w_elapsed_nxt >= {1'b0, r_target});

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start && !bus.i_abort) w_next = S_LOAD;
         S_LOAD: begin
            if (bus.i_abort)        w_next = S_IDLE;
            else if (w_target == '0) w_next = S_DONE;
            else                    w_next = S_COUNT;
         end
         S_COUNT: begin
            if (bus.i_abort)    w_next = S_IDLE;
            else if (w_reached) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_dur     <= '0;
         r_unit    <= '0;
         r_target  <= '0;
         r_elapsed <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (r_state != S_IDLE);
         r_done  <= (r_state == S_DONE);
         r_error <= w_start && (r_state != S_IDLE);
         if (r_state == S_IDLE && w_start && !bus.i_abort) begin
            r_dur  <= bus.i_duration;
            r_unit <= bus.i_unit;
         end
         if (r_state == S_LOAD) begin
            r_target  <= w_target;
            r_elapsed <= '0;
         end else if (r_state == S_COUNT) begin
            r_elapsed <= w_elapsed_nxt;
         end
      end
   end

   assign bus.o_busy               = r_busy;
   assign bus.o_wait_duration_done = r_done;
   assign bus.o_error              = r_error;
endmodule
